// File: rtl/display_scanner_pkg.sv
// Shared constants and helpers for the eight-digit hex display scanner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package disp_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;
  localparam int NIBBLE_W   = 4;
  localparam int DATA_W     = 32;

  // Index of the most significant nonzero nibble. Returns 0 for an all-zero
  // value, so digit position 0 is always treated as significant.
  function automatic logic [SEL_W-1:0] msd_index(input logic [DATA_W-1:0] v);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*NIBBLE_W +: NIBBLE_W] != '0) begin
        idx = SEL_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/display_scanner_tick_gen.sv
// Prescaler: emits a one-cycle tick every CLK_DIV enabled clk cycles.
// Latency: tick is combinational from the count; it is high while the count is CLK_DIV-1.
// Backpressure: enable=0 freezes the count; rst clears it and suppresses tick.
// Ports: clk, rst (sync, active-high), enable (run/hold), tick (output pulse).
module tick_gen #(
  parameter int CLK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (enable && !rst) begin
      if (cnt_q == CNT_MAX) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Multiplexed 8-digit hex display scanner with tear-free double-buffered load.
// Latency: digit follows sel combinationally; a loaded value appears at sel=0 of the frame after acceptance.
// Backpressure: load_ready=~pending; one value may wait in the shadow register, further offers stall.
// Ports: clk, rst (sync, active-high), enable, load_valid/load_data[31:0]/load_ready,
//        digit[3:0], sel[2:0], blank, frame_done (one-cycle pulse on the sel 7->0 tick).
// Build option: define LEADING_ZERO_BLANK_EN to also blank positions above the most
//        significant nonzero nibble of the shown value.
module display_scanner
  import disp_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic [NIBBLE_W-1:0] digit,
  output logic [SEL_W-1:0]  sel,
  output logic              blank,
  output logic              frame_done
);

  logic              tick;
  logic              accept;
  logic [SEL_W-1:0]  sel_q,     sel_d;
  logic [DATA_W-1:0] active_q,  active_d;
  logic [DATA_W-1:0] shadow_q,  shadow_d;
  logic              pending_q, pending_d;

  tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  // tick is already gated by rst, so frame_done stays low during reset.
  assign frame_done = tick && (sel_q == SEL_W'(NUM_DIGITS - 1));
  assign load_ready = !pending_q && !rst;
  assign accept     = load_valid && load_ready;

  always_comb begin
    sel_d     = sel_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    if (tick) begin
      sel_d = sel_q + SEL_W'(1);  // natural 7->0 wrap
    end

    // Swap only at the frame boundary so a frame never mixes two values.
    if (frame_done && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    // An accept on the boundary tick (only possible with pending=0) waits
    // for the next boundary, because the swap above used the old pending.
    if (accept) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign sel   = sel_q;
  assign digit = active_q[sel_q*NIBBLE_W +: NIBBLE_W];

`ifdef LEADING_ZERO_BLANK_EN
  assign blank = !enable || (sel_q > msd_index(active_q));
`else
  assign blank = !enable;
`endif

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready;
  logic [3:0]  digit;
  logic [2:0]  sel;
  logic        blank;
  logic        frame_done;

  always #5 clk = ~clk;

  display_scanner #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .digit      (digit),
    .sel        (sel),
    .blank      (blank),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position derived from the number of enabled cycles
  // since reset, plus a one-deep pending buffer.
  int          m_n = 0;
  logic [31:0] m_active = '0;
  logic [31:0] m_shadow = '0;
  bit          m_pending = 1'b0;
  bit          m_valid = 1'b0;

  function automatic int m_sel();
    return (m_n / CLK_DIV) % 8;
  endfunction

  function automatic bit m_fd();
    return enable && !rst && (m_n % CLK_DIV == CLK_DIV - 1) && (m_sel() == 7);
  endfunction

  function automatic bit m_blank();
    bit b;
    int msd;
    b = !enable;
    msd = 0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 0; i < 8; i++) if (m_active[4*i +: 4] != 4'h0) msd = i;
    if (m_sel() > msd) b = 1'b1;
`endif
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic lv, input logic [31:0] d);
    @(negedge clk);
    rst = r; enable = e; load_valid = lv; load_data = d;
    #1;
    if (m_valid) begin
      chk("sel",        32'(sel),        32'(m_sel()));
      chk("digit",      32'(digit),      (m_active >> (4*m_sel())) & 32'hF);
      chk("load_ready", 32'(load_ready), 32'(!m_pending && !rst));
      chk("blank",      32'(blank),      32'(m_blank()));
      chk("frame_done", 32'(frame_done), 32'(m_fd()));
    end
  endtask

  task automatic adv();
    bit fd;
    bit acc;
    @(posedge clk);
    if (rst) begin
      m_n = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0; m_valid = 1'b1;
    end else begin
      fd  = m_fd();
      acc = load_valid && !m_pending;
      if (fd && m_pending) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end
      if (acc) begin
        m_shadow  = load_data;
        m_pending = 1'b1;
      end
      if (enable) m_n++;
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic lv, input logic [31:0] d);
    drive(r, e, lv, d);
    adv();
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h0);
    chk("rst_sel",   32'(sel),        32'h0);
    chk("rst_digit", 32'(digit),      32'h0);
    chk("rst_fd",    32'(frame_done), 32'h0);
    adv();
  endtask

  typedef struct {
    int          cyc;
    logic        lv;
    logic [31:0] data;
    logic [2:0]  sel;
    logic [3:0]  dig;
    logic        rdy;
    logic        fd;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int          pulses;
    int          last;
    logic        lv;
    logic [31:0] d;
    logic        r;
    logic        e;

    // First-load scenario: value 0x76543210 offered at cycle 2 only.
    tbl[0] = '{0,  1'b0, 32'h0,        3'd0, 4'd0, 1'b1, 1'b0};
    tbl[1] = '{2,  1'b1, 32'h76543210, 3'd0, 4'd0, 1'b1, 1'b0};
    tbl[2] = '{3,  1'b0, 32'h0,        3'd0, 4'd0, 1'b0, 1'b0};
    tbl[3] = '{20, 1'b0, 32'h0,        3'd5, 4'd0, 1'b0, 1'b0};
    tbl[4] = '{31, 1'b0, 32'h0,        3'd7, 4'd0, 1'b0, 1'b1};
    tbl[5] = '{32, 1'b0, 32'h0,        3'd0, 4'd0, 1'b1, 1'b0};
    tbl[6] = '{37, 1'b0, 32'h0,        3'd1, 4'd1, 1'b1, 1'b0};
    tbl[7] = '{45, 1'b0, 32'h0,        3'd3, 4'd3, 1'b1, 1'b0};
    tbl[8] = '{59, 1'b0, 32'h0,        3'd6, 4'd6, 1'b1, 1'b0};
    tbl[9] = '{63, 1'b0, 32'h0,        3'd7, 4'd7, 1'b1, 1'b1};

    do_reset();
    for (int c = 0; c < 64; c++) begin
      lv = 1'b0; d = '0;
      for (int k = 0; k < 10; k++) if (tbl[k].cyc == c) begin lv = tbl[k].lv; d = tbl[k].data; end
      drive(1'b0, 1'b1, lv, d);
      for (int k = 0; k < 10; k++) if (tbl[k].cyc == c) begin
        chk("tbl_sel",   32'(sel),        32'(tbl[k].sel));
        chk("tbl_digit", 32'(digit),      32'(tbl[k].dig));
        chk("tbl_ready", 32'(load_ready), 32'(tbl[k].rdy));
        chk("tbl_fd",    32'(frame_done), 32'(tbl[k].fd));
      end
      adv();
    end

    // load_valid held high: A accepted at once, B waits for the boundary.
    do_reset();
    for (int c = 0; c < 80; c++) begin
      d = (c == 0) ? 32'h89ABCDEF : 32'h01234567;
      drive(1'b0, 1'b1, 1'b1, d);
      if (c == 1)  chk("hold_ready_c1",  32'(load_ready), 32'h0);
      if (c == 31) chk("hold_fd_c31",    32'(frame_done), 32'h1);
      if (c == 32) chk("hold_ready_c32", 32'(load_ready), 32'h1);
      if (c == 32) chk("hold_digit_c32", 32'(digit),      32'hF);
      if (c == 33) chk("hold_ready_c33", 32'(load_ready), 32'h0);
      if (c == 40) chk("hold_digit_c40", 32'(digit),      32'hD);
      if (c == 63) chk("hold_digit_c63", 32'(digit),      32'h8);
      if (c == 64) chk("hold_digit_c64", 32'(digit),      32'h7);
      if (c == 72) chk("hold_digit_c72", 32'(digit),      32'h5);
      adv();
    end

    // Enable dropped at sel=3 mid-dwell, then resumed.
    do_reset();
    for (int c = 0; c < 14; c++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk("hold_sel",   32'(sel),        32'h3);
      chk("hold_blank", 32'(blank),      32'h1);
      chk("hold_fd",    32'(frame_done), 32'h0);
      adv();
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      chk("resume_sel", 32'(sel), (c < 2) ? 32'h3 : 32'h4);
      adv();
    end

    // Reset at sel=5 with a value pending: the pending value is discarded.
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
    for (int c = 1; c <= 20; c++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("midrst_ready0", 32'(load_ready), 32'h0);
    adv();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("midrst_sel",    32'(sel),        32'h0);
    chk("midrst_digit",  32'(digit),      32'h0);
    chk("midrst_ready1", 32'(load_ready), 32'h0);
    adv();
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      if (c == 0) chk("postrst_ready", 32'(load_ready), 32'h1);
      chk("postrst_digit", 32'(digit), 32'h0);
      adv();
    end

    // frame_done cadence over three frames.
    do_reset();
    pulses = 0; last = -1;
    for (int c = 0; c < 100; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      if (frame_done) begin
        pulses++;
        chk("fd_sel", 32'(sel), 32'h7);
        chk("fd_spacing", 32'(c), (last < 0) ? 32'd31 : 32'(last + 32));
        last = c;
      end
      adv();
    end
    chk("fd_count", 32'(pulses), 32'd3);

`ifdef LEADING_ZERO_BLANK_EN
    do_reset();
    for (int c = 0; c < 128; c++) begin
      lv = (c == 0) || (c == 64);
      d  = (c == 0) ? 32'h00000A30 : 32'h0;
      drive(1'b0, 1'b1, lv, d);
      if (c >= 32 && c < 64) chk("lzb_a30", 32'(blank), 32'(((c - 32) / 4) > 2));
      if (c >= 96) begin
        chk("lzb_zero", 32'(blank), 32'(((c - 96) / 4) != 0));
        if (((c - 96) / 4) == 0) chk("lzb_zero_digit", 32'(digit), 32'h0);
      end
      adv();
    end
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 99) == 0);
      e  = ($urandom_range(0, 9) != 0);
      lv = ($urandom_range(0, 3) == 0);
      d  = $urandom;
      d  = d >> (4 * $urandom_range(0, 8));
      cycle(r, e, lv, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000, meaning the number of clk cycles each digit position is shown; legal range 2 to 2^24.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 SHALL have port enable, input, 1 bit: run/hold of the scan.
REQ-005 SHALL have port load_valid, input, 1 bit: a new display value is offered.
REQ-006 SHALL have port load_data, input, 32 bits: eight hex nibbles; nibble i (bits 4i+3:4i) is digit position i.
REQ-007 SHALL have port load_ready, output, 1 bit: the block can accept a value.
REQ-008 SHALL have port digit, output, 4 bits: the nibble currently shown, fed to the 7-segment decoder.
REQ-009 SHALL have port sel, output, 3 bits: the active digit position, fed to the anode decoder.
REQ-010 SHALL have port blank, output, 1 bit: when high, downstream drives all anodes off.
REQ-011 SHALL have port frame_done, output, 1 bit: a one-cycle pulse when a full 8-digit scan completes.

Function
REQ-012 SHALL run a prescaler counter 0..CLK_DIV-1 while enable=1 and assert an internal tick in the cycle the count equals CLK_DIV-1; the count then wraps to 0.
REQ-013 SHALL increment sel by 1 on each tick, wrapping 7->0.
REQ-014 SHALL hold the prescaler, sel, and all other scan state while enable=0, and SHALL force blank=1 during that time.
REQ-015 SHALL drive digit combinationally as nibble sel of the active register; there is zero latency from sel to digit.
REQ-016 SHALL pulse frame_done for exactly one cycle on the tick where sel goes 7->0.
REQ-017 SHALL accept a load when load_valid and load_ready are both 1, capturing load_data into a shadow register and setting pending=1.
REQ-018 SHALL drive load_ready as ~pending, held low while rst=1.
REQ-019 SHALL copy shadow to active and clear pending on the frame_done tick, so sel=0 of the next frame shows the new value; no mid-frame tearing.
REQ-020 When an accept coincides with a frame_done tick while pending=0, the value SHALL wait for the following frame boundary.
REQ-021 SHALL ignore load_data while load_ready=0; there is no overwrite of a pending value.

Reset
REQ-022 rst SHALL, at the next clk edge, clear the prescaler, sel, active, shadow, and pending.
REQ-023 Output values during and after reset SHALL be: digit=0, sel=0, frame_done=0, load_ready=0 while rst is high and 1 the cycle after release, and blank per REQ-014/REQ-026.
REQ-024 rst mid-frame or with pending=1 SHALL discard the pending value, and the scan SHALL restart at sel=0 with a full CLK_DIV dwell.

Configuration
REQ-025 Without macro LEADING_ZERO_BLANK_EN, blank SHALL equal ~enable.
REQ-026 With LEADING_ZERO_BLANK_EN defined, blank SHALL also be 1 when sel is above the index of the most significant nonzero nibble of active. Position 0 is never blanked by this rule, so an all-zero value shows a single "0".

Structure
REQ-027 Package disp_pkg SHALL hold NUM_DIGITS=8, SEL_W=3, NIBBLE_W=4, and DATA_W=32.
REQ-028 The prescaler SHALL be a sub-module, tick_gen (parameter CLK_DIV, ports clk, rst, enable, tick), with counter width $clog2(CLK_DIV).

Verification (CLK_DIV=4 for all scenarios)
REQ-029 Reset, enable=1, offer 0x76543210 at cycle 2 -> load_ready falls next cycle; digit=0 on every position through the first frame; from the cycle after the first frame_done, sel 0..7 shows digit 0..7, each for 4 cycles.
REQ-030 Hold load_valid=1 continuously with values A then B -> A is accepted, B is not accepted until load_ready returns the cycle after frame_done, and B displays one frame after that.
REQ-031 Drop enable at sel=3 mid-dwell for 10 cycles -> sel stays 3, blank=1, and the remaining dwell resumes exactly where it stopped.
REQ-032 Assert rst at sel=5 with pending=1 -> next cycle sel=0, digit=0, load_ready=0; after release load_ready=1 and the old pending value never appears.
REQ-033 With LEADING_ZERO_BLANK_EN and active=0x00000A30 -> blank=1 at sel 3..7 and blank=0 at sel 0..2; with active=0 -> only sel 0 is unblanked, showing digit 0.
REQ-034 Check frame_done over 3 frames -> exactly one pulse every 32 cycles, coincident with sel 7->0.
